// File: rtl/md_unit.sv
// Iterative 32-cycle multiply/divide unit: shift-add multiply, restoring divide,
// start/busy/done handshake with results held in HI/LO until the next operation.
module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Control state (reset)
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Operation context and datapath (no reset needed)
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               zero_div_q, zero_div_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;

   // Operand conditioning at acceptance: op[0] selects the signed variants.
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign a_neg = op[0] & a_in[WIDTH-1];
   assign b_neg = op[0] & b_in[WIDTH-1];
   assign a_mag = a_neg ? (~a_in + WIDTH'(1)) : a_in;
   assign b_mag = b_neg ? (~b_in + WIDTH'(1)) : b_in;

   // One shift-add multiply step: add multiplicand into the upper half, shift right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring divide step on {rem, quot}; compare is WIDTH+1 bits wide.
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_sub;
   logic               rem_ge;
   logic [2*WIDTH-1:0] div_next;

   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign rem_ge   = rem_sh >= {1'b0, opnd_q};
   assign rem_sub  = rem_sh - {1'b0, opnd_q};
   assign div_next = rem_ge ? {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};

   // Sign fix-up applied in FIX.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign prod_fix = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
   assign quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                               : acc_q[2*WIDTH-1:WIDTH];

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      dbz_d      = dbz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      zero_div_d = zero_div_q;
      a_raw_d    = a_raw_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RUN;
               cnt_d      = '0;
               dbz_d      = 1'b0;
               is_div_d   = op[1];
               neg_res_d  = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               zero_div_d = op[1] & (b_in == '0);
               a_raw_d    = a_in;
               // Multiply iterates over the multiplier; divide over the dividend.
               opnd_d     = op[1] ? b_mag : a_mag;
               acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            end
         end

         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (zero_div_q) begin
               lo_d  = '1;
               hi_d  = a_raw_q;
               dbz_d = 1'b1;
            end else begin
               lo_d = quot_fix;
               hi_d = rem_fix;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // NOTE: datapath registers are left unreset; each is loaded on acceptance before use.
   always_ff @(posedge clk) begin
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      a_raw_q    <= a_raw_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int          n_checks;
   int          n_errors;
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   md_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a_in        (a_in),
      .b_in        (b_in),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero.
   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl, output logic rz);
      logic [63:0] p;
      longint      sa, sb, q, r;
      rz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin p = 64'(a) * 64'(b); rh = p[63:32]; rl = p[31:0]; end
         2'b01: begin p = 64'(sa * sb);    rh = p[63:32]; rl = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               rl = 32'hFFFF_FFFF; rh = a; rz = 1'b1;
            end else if (o == 2'b10) begin
               rl = a / b; rh = a % b;
            end else begin
               q = sa / sb; r = sa % sb;
               rl = q[31:0]; rh = r[31:0];
            end
         end
      endcase
   endfunction

   // Issues an op at the current negedge and follows it to its done cycle.
   // With hold=1, start stays high with scrambled operands throughout busy.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
      logic [31:0] eh, el;
      logic        ez;
      int          n, busy_n;
      bit          seen, overlap;
      ref_model(o, a, b, eh, el, ez);
      op = o; a_in = a; b_in = b; start = 1'b1;
      n = 0; busy_n = 0; seen = 1'b0; overlap = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (busy) busy_n++;
         if (busy && done) overlap = 1'b1;
         if (n == 1) check({name, ".dbz_clear"}, 64'(div_by_zero), 64'd0);
         if (n == 16) begin
            check({name, ".hold_hi"}, 64'(hi), 64'(prev_hi));
            check({name, ".hold_lo"}, 64'(lo), 64'(prev_lo));
         end
         if (done) seen = 1'b1;
         if (hold && !seen) begin
            start = 1'b1; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
         end else begin
            start = 1'b0;
         end
      end
      check({name, ".latency"}, 64'(n), 64'd34);
      check({name, ".busy_cycles"}, 64'(busy_n), 64'd33);
      check({name, ".busy_done_overlap"}, 64'(overlap), 64'd0);
      check({name, ".hi"}, 64'(hi), 64'(eh));
      check({name, ".lo"}, 64'(lo), 64'(el));
      check({name, ".dbz"}, 64'(div_by_zero), 64'(ez));
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      bit          done_seen;

      n_checks = 0; n_errors = 0;
      prev_hi = 32'd0; prev_lo = 32'd0;
      reset = 1'b1; start = 1'b0; op = 2'b00; a_in = 32'd0; b_in = 32'd0;
      repeat (3) @(negedge clk);
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.hi", 64'(hi), 64'd0);
      check("reset.lo", 64'(lo), 64'd0);
      check("reset.dbz", 64'(div_by_zero), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max.hi_const", 64'(hi), 64'hFFFF_FFFE);
      check("multu_max.lo_const", 64'(lo), 64'h0000_0001);
      @(negedge clk);

      run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
      check("mult_neg3x7.hi_const", 64'(hi), 64'hFFFF_FFFF);
      check("mult_neg3x7.lo_const", 64'(lo), 64'hFFFF_FFEB);
      run_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
      check("mult_minsq.hi_const", 64'(hi), 64'h4000_0000);
      check("mult_minsq.lo_const", 64'(lo), 64'h0000_0000);

      run_op("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg7by2.lo_const", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg7by2.hi_const", 64'(hi), 64'hFFFF_FFFF);
      run_op("divu_100by7", 2'b10, 32'd100, 32'd7, 1'b0);
      check("divu_100by7.lo_const", 64'(lo), 64'd14);
      check("divu_100by7.hi_const", 64'(hi), 64'd2);

      run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 1'b0);
      check("divu_by0.lo_const", 64'(lo), 64'hFFFF_FFFF);
      check("divu_by0.hi_const", 64'(hi), 64'h0000_1234);
      check("divu_by0.dbz_const", 64'(div_by_zero), 64'd1);
      @(negedge clk);
      check("divu_by0.dbz_held", 64'(div_by_zero), 64'd1);
      run_op("div_min_by_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_min_by_m1.lo_const", 64'(lo), 64'h8000_0000);
      check("div_min_by_m1.hi_const", 64'(hi), 64'h0000_0000);
      check("div_min_by_m1.dbz_const", 64'(div_by_zero), 64'd0);
      run_op("div_by0_signed", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);

      // Start held high through busy, then a start issued in the done cycle.
      @(negedge clk);
      run_op("hold_start", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
      run_op("back_to_back", 2'b10, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);

      // Reset sampled at E15 of a MULTU.
      @(negedge clk);
      op = 2'b00; a_in = 32'hCAFE_F00D; b_in = 32'h0BAD_BEEF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.hi", 64'(hi), 64'd0);
      check("abort.lo", 64'(lo), 64'd0);
      done_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) done_seen = 1'b1;
      end
      check("abort.no_done", 64'(done_seen), 64'd0);
      prev_hi = 32'd0; prev_lo = 32'd0;
      run_op("after_abort", 2'b00, 32'h0001_0003, 32'h0002_0005, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
